// File: rtl/axi_pkg.sv
// Shared AXI read-path types and widths.
// Optional feature macro: AXI_RD_DECERR_EN (decode-error responder for unmapped reads).
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package axi_pkg;
  localparam int ID_BITS   = `AXI_ID_BITS;
  localparam int ADDR_BITS = `AXI_ADDR_BITS;
  localparam int LEN_BITS  = `AXI_LEN_BITS;
  localparam int SIZE_BITS = `AXI_SIZE_BITS;
  localparam int IDS_BITS  = `AXI_IDS_BITS;
  localparam int DATA_BITS = `AXI_DATA_BITS;

  localparam logic [31:0] S0_BASE_DEF  = 32'h0000_0000;
  localparam logic [31:0] S1_BASE_DEF  = 32'h0001_0000;
  localparam int          WIN_BITS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    DEFAULT = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    SLV_S0  = 2'd0,
    SLV_S1  = 2'd1,
    SLV_DEF = 2'd2
  } slv_sel_e;
endpackage

// File: rtl/read_address_decoder_decode.sv
// Combinational address -> slave decode, shared with the write-address path.
// Optional feature macro: AXI_RD_DECERR_EN (full window compare, unmapped -> SLV_DEF).
module ar_addr_decode
  import axi_pkg::*;
#(
  parameter logic [31:0] S0_BASE  = S0_BASE_DEF,
  parameter logic [31:0] S1_BASE  = S1_BASE_DEF,
  parameter int          WIN_BITS = WIN_BITS_DEF
) (
  input  logic [ADDR_BITS-1:0] addr,
  output slv_sel_e             sel
);

`ifdef AXI_RD_DECERR_EN
  // Full upper-address compare against both windows; anything else is unmapped.
  always_comb begin
    sel = SLV_DEF;
    if (addr[31:WIN_BITS] == S0_BASE[31:WIN_BITS])      sel = SLV_S0;
    else if (addr[31:WIN_BITS] == S1_BASE[31:WIN_BITS]) sel = SLV_S1;
  end
`else
  // Only the bit separating the two windows matters; upper bits alias.
  logic unused_bits;
  assign unused_bits = ^{addr[ADDR_BITS-1:WIN_BITS+1], addr[WIN_BITS-1:0], S0_BASE};

  always_comb begin
    sel = (addr[WIN_BITS] == S1_BASE[WIN_BITS]) ? SLV_S1 : SLV_S0;
  end
`endif

endmodule

// File: rtl/read_address_decoder.sv
// AR-channel slice: accepts one arbitrated read, forwards it to the decoded
// slave, and holds the {master, slave} routing context until RLAST.
// Optional feature macro: AXI_RD_DECERR_EN (internal DECERR responder).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and payload is held stable while
// valid is high and ready is low.
module read_address_decoder
  import axi_pkg::*;
#(
  parameter logic [31:0] S0_BASE  = S0_BASE_DEF,
  parameter logic [31:0] S1_BASE  = S1_BASE_DEF,
  parameter int          WIN_BITS = WIN_BITS_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [ID_BITS-1:0]   ARID_ARB,
  input  logic [ADDR_BITS-1:0] ARADDR_ARB,
  input  logic [LEN_BITS-1:0]  ARLEN_ARB,
  input  logic [SIZE_BITS-1:0] ARSIZE_ARB,
  input  logic [1:0]           ARBURST_ARB,
  input  logic                 ARVALID_ARB,
  input  logic                 ARMST_ARB,
  output logic                 ARREADY_ARB,
  output logic [IDS_BITS-1:0]  ARID_S,
  output logic [ADDR_BITS-1:0] ARADDR_S,
  output logic [LEN_BITS-1:0]  ARLEN_S,
  output logic [SIZE_BITS-1:0] ARSIZE_S,
  output logic [1:0]           ARBURST_S,
  output logic                 ARVALID_S0,
  output logic                 ARVALID_S1,
  input  logic                 ARREADY_S0,
  input  logic                 ARREADY_S1,
  input  logic                 RVALID_SEL,
  input  logic                 RREADY_SEL,
  input  logic                 RLAST_SEL,
`ifdef AXI_RD_DECERR_EN
  output logic                 RVALID_D,
  output logic [IDS_BITS-1:0]  RID_D,
  output logic [1:0]           RRESP_D,
  output logic                 RLAST_D,
  output logic [DATA_BITS-1:0] RDATA_D,
`endif
  output logic                 RD_BUSY,
  output logic                 RD_MST,
  output logic [1:0]           RD_SLV,
  output logic [1:0]           rd_state
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ADDR    = ADDR;
  localparam logic [1:0] ST_DATA    = DATA;
  localparam logic [1:0] ST_DEFAULT = DEFAULT;

  logic [1:0]         state_q, state_d;
  logic [ID_BITS-1:0] id_q;
  slv_sel_e           dec_sel;
  logic               accept, slv_ready, r_done;

  ar_addr_decode #(
    .S0_BASE (S0_BASE),
    .S1_BASE (S1_BASE),
    .WIN_BITS(WIN_BITS)
  ) u_decode (
    .addr(ARADDR_ARB),
    .sel (dec_sel)
  );

  assign accept    = ARVALID_ARB & ARREADY_ARB;
  assign slv_ready = (RD_SLV == SLV_S1) ? ARREADY_S1 : ARREADY_S0;
  assign r_done    = RVALID_SEL & RREADY_SEL & RLAST_SEL;

`ifdef AXI_RD_DECERR_EN
  logic [LEN_BITS-1:0] beat_q;
  logic                last_beat;
  assign last_beat = (beat_q == ARLEN_S);

  // Beat counter for the internal error responder; restarts on each accept.
  always_ff @(posedge ACLK) begin
    if (ARESET || accept)                            beat_q <= '0;
    else if (state_q == ST_DEFAULT && RREADY_SEL)    beat_q <= beat_q + 1'b1;
  end

  assign RVALID_D = (state_q == ST_DEFAULT);
  assign RID_D    = ARID_S;
  assign RRESP_D  = 2'b11;
  assign RLAST_D  = RVALID_D & last_beat;
  assign RDATA_D  = '0;
`endif

  // Next-state logic for the single-outstanding read sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (dec_sel == SLV_DEF) ? ST_DEFAULT : ST_ADDR;
      ST_ADDR: if (slv_ready) state_d = ST_DATA;
      ST_DATA: if (r_done) state_d = ST_IDLE;
`ifdef AXI_RD_DECERR_EN
      ST_DEFAULT: if (RREADY_SEL && last_beat) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and captured request / routing context.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      ARADDR_S  <= '0;
      ARLEN_S   <= '0;
      ARSIZE_S  <= '0;
      ARBURST_S <= '0;
      RD_MST    <= 1'b0;
      RD_SLV    <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q      <= ARID_ARB;
        ARADDR_S  <= ARADDR_ARB;
        ARLEN_S   <= ARLEN_ARB;
        ARSIZE_S  <= ARSIZE_ARB;
        ARBURST_S <= ARBURST_ARB;
        RD_MST    <= ARMST_ARB;
        RD_SLV    <= dec_sel;
      end
    end
  end

  assign ARREADY_ARB = (state_q == ST_IDLE) & ~ARESET;
  assign ARVALID_S0  = (state_q == ST_ADDR) & (RD_SLV == SLV_S0);
  assign ARVALID_S1  = (state_q == ST_ADDR) & (RD_SLV == SLV_S1);
  assign ARID_S      = {4'(RD_MST), id_q};
  assign RD_BUSY     = (state_q == ST_DATA) | (state_q == ST_DEFAULT);
  assign rd_state    = state_q;

endmodule

// File: tb/tb_read_address_decoder.sv
// Directed, table-driven bench for read_address_decoder.
// Optional feature macro: AXI_RD_DECERR_EN (adds the decode-error sequence).
module tb_read_address_decoder;
  import axi_pkg::*;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic [ID_BITS-1:0]   ARID_ARB;
  logic [ADDR_BITS-1:0] ARADDR_ARB;
  logic [LEN_BITS-1:0]  ARLEN_ARB;
  logic [SIZE_BITS-1:0] ARSIZE_ARB;
  logic [1:0]           ARBURST_ARB;
  logic                 ARVALID_ARB, ARMST_ARB, ARREADY_ARB;
  logic [IDS_BITS-1:0]  ARID_S;
  logic [ADDR_BITS-1:0] ARADDR_S;
  logic [LEN_BITS-1:0]  ARLEN_S;
  logic [SIZE_BITS-1:0] ARSIZE_S;
  logic [1:0]           ARBURST_S;
  logic                 ARVALID_S0, ARVALID_S1, ARREADY_S0, ARREADY_S1;
  logic                 RVALID_SEL, RREADY_SEL, RLAST_SEL;
  logic                 RD_BUSY, RD_MST;
  logic [1:0]           RD_SLV, rd_state;
`ifdef AXI_RD_DECERR_EN
  logic                 RVALID_D, RLAST_D;
  logic [IDS_BITS-1:0]  RID_D;
  logic [1:0]           RRESP_D;
  logic [DATA_BITS-1:0] RDATA_D;
`endif

  read_address_decoder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_ARB(ARID_ARB), .ARADDR_ARB(ARADDR_ARB), .ARLEN_ARB(ARLEN_ARB),
    .ARSIZE_ARB(ARSIZE_ARB), .ARBURST_ARB(ARBURST_ARB), .ARVALID_ARB(ARVALID_ARB),
    .ARMST_ARB(ARMST_ARB), .ARREADY_ARB(ARREADY_ARB),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1),
    .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
    .RVALID_SEL(RVALID_SEL), .RREADY_SEL(RREADY_SEL), .RLAST_SEL(RLAST_SEL),
`ifdef AXI_RD_DECERR_EN
    .RVALID_D(RVALID_D), .RID_D(RID_D), .RRESP_D(RRESP_D), .RLAST_D(RLAST_D),
    .RDATA_D(RDATA_D),
`endif
    .RD_BUSY(RD_BUSY), .RD_MST(RD_MST), .RD_SLV(RD_SLV), .rd_state(rd_state)
  );

  // Clock and watchdog
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic        mst;
    int          delay;
    logic [1:0]  exp_slv;
  } vec_t;

  vec_t vecs[5];
  int tests_run = 0;
  int tests_failed = 0;
  logic [IDS_BITS-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Holds ARESET across one edge and checks the reset values while it is high.
  task automatic apply_reset(input string tag);
    ARESET = 1'b1;
    tick();
    check({tag, "_arready"}, ARREADY_ARB, 0);
    check({tag, "_arvalid"}, {ARVALID_S0, ARVALID_S1}, 0);
    check({tag, "_busy"}, RD_BUSY, 0);
    check({tag, "_mst_slv"}, {RD_MST, RD_SLV}, 0);
    check({tag, "_payload"}, {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}, 0);
    check({tag, "_state"}, rd_state, 0);
    ARESET = 1'b0;
    exp_q.delete();
    #1;
    check({tag, "_arready_after"}, ARREADY_ARB, 1);
  endtask

  // Drives one request on the arbitrated AR channel for a single accept cycle.
  task automatic issue(input vec_t v);
    ARADDR_ARB  = v.addr;
    ARID_ARB    = v.id;
    ARLEN_ARB   = v.len;
    ARMST_ARB   = v.mst;
    ARSIZE_ARB  = 3'd2;
    ARBURST_ARB = 2'b01;
    ARVALID_ARB = 1'b1;
    check("issue_arready", ARREADY_ARB, 1);
    exp_q.push_back({4'(v.mst), v.id});
    tick();
    ARVALID_ARB = 1'b0;
    ARADDR_ARB  = 32'hDEAD_BEEF;
    ARLEN_ARB   = 4'h7;
  endtask

  // Slave address handshake after 'delay' wait cycles.
  task automatic addr_phase(input vec_t v);
    int  n = 0;
    bit  done = 0;
    logic sel_v, oth_v, rdy;
    check("addr_arready_low", ARREADY_ARB, 0);
    check("addr_route", {RD_MST, RD_SLV}, {v.mst, v.exp_slv});
    check("addr_payload", {ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S},
          {v.addr, v.len, 3'd2, 2'b01});
    while (!done && n < 20) begin
      sel_v = v.exp_slv[0] ? ARVALID_S1 : ARVALID_S0;
      oth_v = v.exp_slv[0] ? ARVALID_S0 : ARVALID_S1;
      if (oth_v) check("addr_other_valid", oth_v, 0);
      if (sel_v) n++;
      rdy = (n == v.delay + 1);
      ARREADY_S0 = rdy & ~v.exp_slv[0];
      ARREADY_S1 = rdy & v.exp_slv[0];
      if (rdy) begin
        if (exp_q.size() == 0) check("arid_queue_empty", 1, 0);
        else check("arid_s", ARID_S, exp_q.pop_front());
      end
      tick();
      if (rdy) done = 1;
    end
    ARREADY_S0 = 1'b0;
    ARREADY_S1 = 1'b0;
    if (!done) check("addr_timeout", 0, 1);
    check("arvalid_cycles", n, v.delay + 1);
    check("arvalid_dropped", {ARVALID_S0, ARVALID_S1}, 0);
    check("busy_in_data", RD_BUSY, 1);
  endtask

  // Returns len+1 beats; two decoy cycles before the last beat must not end the burst.
  task automatic data_phase(input logic [3:0] len);
    bit busy_ok = 1;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == int'(len)) begin
        RVALID_SEL = 0; RREADY_SEL = 1; RLAST_SEL = 1;
        tick();
        if (!RD_BUSY || ARREADY_ARB) busy_ok = 0;
        RVALID_SEL = 1; RREADY_SEL = 0; RLAST_SEL = 1;
        tick();
        if (!RD_BUSY || ARREADY_ARB) busy_ok = 0;
      end
      RVALID_SEL = 1; RREADY_SEL = 1; RLAST_SEL = (b == int'(len));
      if (!RD_BUSY || ARREADY_ARB) busy_ok = 0;
      tick();
    end
    RVALID_SEL = 0; RREADY_SEL = 0; RLAST_SEL = 0;
    check("busy_held_until_rlast", busy_ok, 1);
    check("busy_cleared", RD_BUSY, 0);
    check("idle_after_rlast", {rd_state, ARREADY_ARB}, {2'd0, 1'b1});
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_0040, 4'h5, 4'd3,  1'b0, 2, 2'd0};
    vecs[1] = '{32'h0001_0010, 4'hA, 4'd0,  1'b1, 0, 2'd1};
    vecs[2] = '{32'h0000_FFFC, 4'h3, 4'd15, 1'b1, 1, 2'd0};
    vecs[3] = '{32'h0001_FFFC, 4'hF, 4'd1,  1'b0, 0, 2'd1};
`ifdef AXI_RD_DECERR_EN
    vecs[4] = '{32'h0001_0000, 4'h6, 4'd2,  1'b1, 3, 2'd1};
`else
    vecs[4] = '{32'h2001_0000, 4'h6, 4'd2,  1'b1, 3, 2'd1};
`endif

    ARESET = 1; ARID_ARB = 0; ARADDR_ARB = 0; ARLEN_ARB = 0; ARSIZE_ARB = 0;
    ARBURST_ARB = 0; ARVALID_ARB = 0; ARMST_ARB = 0; ARREADY_S0 = 0; ARREADY_S1 = 0;
    RVALID_SEL = 0; RREADY_SEL = 0; RLAST_SEL = 0;
    tick();
    apply_reset("por");

    // Table-driven transactions
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i]);
      addr_phase(vecs[i]);
      data_phase(vecs[i].len);
    end

    // Second request held during DATA: accepted only once back in IDLE
    v = '{32'h0000_0100, 4'h1, 4'd1, 1'b0, 0, 2'd0};
    issue(v);
    addr_phase(v);
    v = '{32'h0001_0020, 4'h9, 4'd0, 1'b1, 0, 2'd1};
    ARADDR_ARB = v.addr; ARID_ARB = v.id; ARLEN_ARB = v.len; ARMST_ARB = v.mst;
    ARSIZE_ARB = 3'd2; ARBURST_ARB = 2'b01; ARVALID_ARB = 1'b1;
    data_phase(4'd1);
    check("pending_not_forwarded", ARVALID_S1, 0);
    exp_q.push_back({4'(v.mst), v.id});
    tick();
    ARVALID_ARB = 1'b0;
    check("turnaround_arvalid_s1", ARVALID_S1, 1);
    addr_phase(v);
    data_phase(v.len);

    // Reset while in ADDR
    v = '{32'h0001_0400, 4'h7, 4'd2, 1'b1, 5, 2'd1};
    issue(v);
    check("pre_reset_addr_state", rd_state, 2'd1);
    apply_reset("rst_addr");

    // Reset while in DATA
    v = '{32'h0001_0800, 4'hC, 4'd3, 1'b1, 0, 2'd1};
    issue(v);
    addr_phase(v);
    RVALID_SEL = 1; RREADY_SEL = 1; RLAST_SEL = 0;
    tick();
    RVALID_SEL = 0; RREADY_SEL = 0;
    apply_reset("rst_data");

`ifdef AXI_RD_DECERR_EN
    // Unmapped address: internal two-beat DECERR, no slave request
    v = '{32'h2000_0000, 4'h4, 4'd1, 1'b1, 0, 2'd2};
    issue(v);
    check("dec_route", {RD_MST, RD_SLV, rd_state}, {1'b1, 2'd2, 2'd3});
    check("dec_no_slave", {ARVALID_S0, ARVALID_S1}, 0);
    check("dec_beat1", {RVALID_D, RRESP_D, RLAST_D, RDATA_D}, {1'b1, 2'b11, 1'b0, 32'h0});
    check("dec_rid", RID_D, {4'h1, 4'h4});
    RREADY_SEL = 1;
    tick();
    check("dec_beat2", {RVALID_D, RRESP_D, RLAST_D}, {1'b1, 2'b11, 1'b1});
    tick();
    RREADY_SEL = 0;
    check("dec_idle", {rd_state, RVALID_D, RD_BUSY}, {2'd0, 1'b0, 1'b0});
    exp_q.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
